// File: rtl/lcd_scan_gen.sv
// ============================================================================
// lcd_scan_gen : parametrised LCD raster / pixel-request / output-pin generator
// Optional test-pattern bars enabled by defining LCD_SCAN_TEST_PATTERN_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lcd_scan_gen #(
  parameter int          H_SYNC       = 1,
  parameter int          H_BP         = 45,
  parameter int          H_ACT        = 800,
  parameter int          H_FP         = 210,
  parameter int          V_SYNC       = 1,
  parameter int          V_BP         = 22,
  parameter int          V_ACT        = 480,
  parameter int          V_FP         = 22,
  parameter int          COLOR_W      = 8,
  parameter int          RD_LAT       = 2,
  parameter bit          SYNC_ACT_LOW = 1'b1,
  parameter logic [23:0] UF_COLOR     = 24'hFF00FF
) (
  input  logic                   iCLK,
  input  logic                   iRST_n,
  input  logic                   iEN,
  input  logic [3*COLOR_W-1:0]   iRD_DATA,
  input  logic                   iRD_VALID,
  input  logic                   iUF_CLR,
`ifdef LCD_SCAN_TEST_PATTERN_EN
  input  logic                   iPATTERN,
`endif
  output logic                   oRD_REQ,
  output logic                   oNew_Frame,
  output logic                   oEnd_Frame,
  output logic                   oRUN,
  output logic                   oUNDERFLOW,
  output logic                   oHD,
  output logic                   oVD,
  output logic                   oDE,
  output logic [COLOR_W-1:0]     oLCD_R,
  output logic [COLOR_W-1:0]     oLCD_G,
  output logic [COLOR_W-1:0]     oLCD_B
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam int PW      = 3 * COLOR_W;
  localparam int DW      = $clog2(RD_LAT + 1);

  localparam logic [XW-1:0] c_xLast    = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] c_yLast    = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] c_hsEnd    = XW'(H_SYNC);
  localparam logic [YW-1:0] c_vsEnd    = YW'(V_SYNC);
  localparam logic [XW-1:0] c_xAct0    = XW'(H_SYNC + H_BP);
  localparam logic [YW-1:0] c_yAct0    = YW'(V_SYNC + V_BP);
  localparam logic [XW:0]   c_xActEnd  = (XW+1)'(H_SYNC + H_BP + H_ACT);
  localparam logic [YW:0]   c_yActEnd  = (YW+1)'(V_SYNC + V_BP + V_ACT);
  localparam logic [XW-1:0] c_xActLast = XW'(H_SYNC + H_BP + H_ACT - 1);
  localparam logic [YW-1:0] c_yActLast = YW'(V_SYNC + V_BP + V_ACT - 1);
  localparam logic [DW-1:0] c_drainLast = DW'(RD_LAT);

  // Zero-extend or truncate the 24-bit underflow colour to the pixel width.
  function automatic logic [PW-1:0] fitColor(input logic [23:0] c);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < PW; i++) begin
      if (i < 24) r[i] = c[i];
    end
    return r;
  endfunction

  localparam logic [PW-1:0] c_ufColor = fitColor(UF_COLOR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          r_state, w_stateNext;
  logic [XW-1:0]   r_x, w_xNext;
  logic [YW-1:0]   r_y, w_yNext;
  logic            r_stopPend, w_stopNext;
  logic [DW-1:0]   r_drain, w_drainNext;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state    <= IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_stopPend <= 1'b0;
      r_drain    <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_x        <= w_xNext;
      r_y        <= w_yNext;
      r_stopPend <= w_stopNext;
      r_drain    <= w_drainNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_xNext     = r_x;
    w_yNext     = r_y;
    w_stopNext  = r_stopPend;
    w_drainNext = r_drain;
    unique case (r_state)
      IDLE: begin
        w_xNext    = '0;
        w_yNext    = '0;
        w_stopNext = 1'b0;
        if (iEN) w_stateNext = RUN;
      end
      RUN: begin
        // Stop request tracks the latest iEN; only acted on at the frame wrap.
        w_stopNext = ~iEN;
        if (r_x == c_xLast) begin
          w_xNext = '0;
          if (r_y == c_yLast) begin
            w_yNext = '0;
            if (r_stopPend) begin
              w_stateNext = DRAIN;
              w_drainNext = '0;
              w_stopNext  = 1'b0;
            end
          end else begin
            w_yNext = r_y + 1'b1;
          end
        end else begin
          w_xNext = r_x + 1'b1;
        end
      end
      DRAIN: begin
        if (r_drain == c_drainLast) w_stateNext = IDLE;
        else                        w_drainNext = r_drain + 1'b1;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  logic w_run, w_hs, w_vs, w_act, w_xAct, w_yAct;

  assign w_run  = (r_state == RUN);
  assign w_xAct = (r_x >= c_xAct0) && ({1'b0, r_x} < c_xActEnd);
  assign w_yAct = (r_y >= c_yAct0) && ({1'b0, r_y} < c_yActEnd);
  assign w_hs   = w_run && (r_x < c_hsEnd);
  assign w_vs   = w_run && (r_y < c_vsEnd);
  assign w_act  = w_run && w_xAct && w_yAct;

  assign oRD_REQ    = w_act;
  assign oNew_Frame = w_run && (r_x == '0) && (r_y == '0);
  assign oEnd_Frame = w_act && (r_x == c_xActLast) && (r_y == c_yActLast);
  assign oRUN       = (r_state != IDLE);

  logic [RD_LAT-1:0] r_hsPipe, r_vsPipe, r_actPipe;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_hsPipe  <= '0;
      r_vsPipe  <= '0;
      r_actPipe <= '0;
    end else begin
      r_hsPipe[0]  <= w_hs;
      r_vsPipe[0]  <= w_vs;
      r_actPipe[0] <= w_act;
      for (int i = 1; i < RD_LAT; i++) begin
        r_hsPipe[i]  <= r_hsPipe[i-1];
        r_vsPipe[i]  <= r_vsPipe[i-1];
        r_actPipe[i] <= r_actPipe[i-1];
      end
    end
  end

  logic          w_actD;
  logic          w_patOn;
  logic [PW-1:0] w_barRgb;

  assign w_actD = r_actPipe[RD_LAT-1];

`ifdef LCD_SCAN_TEST_PATTERN_EN
  localparam logic [XW-1:0] c_barW = XW'(H_ACT / 8);

  logic [2:0]    r_barPipe [RD_LAT];
  logic [XW-1:0] w_xRel;
  logic [2:0]    w_barIdx;
  logic [2:0]    w_bar;

  assign w_xRel   = r_x - c_xAct0;
  assign w_barIdx = 3'(w_xRel / c_barW);
  assign w_bar    = r_barPipe[RD_LAT-1];

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int i = 0; i < RD_LAT; i++) r_barPipe[i] <= '0;
    end else begin
      r_barPipe[0] <= w_barIdx;
      for (int i = 1; i < RD_LAT; i++) r_barPipe[i] <= r_barPipe[i-1];
    end
  end

  // Bars white,yellow,cyan,green,magenta,red,blue,black reduce to inverted index bits.
  assign w_patOn  = iPATTERN;
  assign w_barRgb = {{COLOR_W{~w_bar[1]}}, {COLOR_W{~w_bar[2]}}, {COLOR_W{~w_bar[0]}}};
`else
  assign w_patOn  = 1'b0;
  assign w_barRgb = '0;
`endif

  logic [PW-1:0] w_rgb;
  logic          w_ufSet;

  always_comb begin
    w_rgb   = '0;
    w_ufSet = 1'b0;
    if (w_actD) begin
      if (w_patOn) begin
        w_rgb = w_barRgb;
      end else if (iRD_VALID) begin
        w_rgb = iRD_DATA;
      end else begin
        w_rgb   = c_ufColor;
        w_ufSet = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oHD        <= SYNC_ACT_LOW;
      oVD        <= SYNC_ACT_LOW;
      oDE        <= 1'b0;
      oLCD_R     <= '0;
      oLCD_G     <= '0;
      oLCD_B     <= '0;
      oUNDERFLOW <= 1'b0;
    end else begin
      oHD                      <= r_hsPipe[RD_LAT-1] ^ SYNC_ACT_LOW;
      oVD                      <= r_vsPipe[RD_LAT-1] ^ SYNC_ACT_LOW;
      oDE                      <= w_actD;
      {oLCD_R, oLCD_G, oLCD_B} <= w_rgb;
      // A new underflow outranks a clear in the same cycle.
      oUNDERFLOW               <= w_ufSet | (oUNDERFLOW & ~iUF_CLR);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lcd_scan_gen.sv
// ============================================================================
// tb_lcd_scan_gen : two small-timing instances checked cycle by cycle against
// a frame-time model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lcd_scan_gen;

  localparam int HS = 2, HBP = 3, HACT = 16, HFP = 3;
  localparam int VS = 1, VBP = 2, VACT = 4, VFP = 2;
  localparam int HT = HS + HBP + HACT + HFP;
  localparam int VT = VS + VBP + VACT + VFP;
  localparam int FT = HT * VT;
  localparam int HA0 = HS + HBP;
  localparam int VA0 = VS + VBP;
  localparam int LAT0 = 2, LAT1 = 4;
  localparam int STOP_T = 60;

  logic iCLK = 1'b0, iRST_n = 1'b1, iEN = 1'b0, iRD_VALID = 1'b0, iUF_CLR = 1'b0;
  logic [23:0] data0 = '0;
  logic [17:0] data1 = '0;

  logic req0, nf0, ef0, run0, uf0, hd0, vd0, de0;
  logic [7:0] r0, g0, b0;
  logic req1, nf1, ef1, run1, uf1, hd1, vd1, de1;
  logic [5:0] r1, g1, b1;

  lcd_scan_gen #(.H_SYNC(HS), .H_BP(HBP), .H_ACT(HACT), .H_FP(HFP),
                 .V_SYNC(VS), .V_BP(VBP), .V_ACT(VACT), .V_FP(VFP),
                 .COLOR_W(8), .RD_LAT(LAT0), .SYNC_ACT_LOW(1'b1), .UF_COLOR(24'hFF00FF)) u0 (
    .iCLK(iCLK), .iRST_n(iRST_n), .iEN(iEN), .iRD_DATA(data0), .iRD_VALID(iRD_VALID),
    .iUF_CLR(iUF_CLR), .oRD_REQ(req0), .oNew_Frame(nf0), .oEnd_Frame(ef0), .oRUN(run0),
    .oUNDERFLOW(uf0), .oHD(hd0), .oVD(vd0), .oDE(de0), .oLCD_R(r0), .oLCD_G(g0), .oLCD_B(b0));

  lcd_scan_gen #(.H_SYNC(HS), .H_BP(HBP), .H_ACT(HACT), .H_FP(HFP),
                 .V_SYNC(VS), .V_BP(VBP), .V_ACT(VACT), .V_FP(VFP),
                 .COLOR_W(6), .RD_LAT(LAT1), .SYNC_ACT_LOW(1'b0), .UF_COLOR(24'hFF00FF)) u1 (
    .iCLK(iCLK), .iRST_n(iRST_n), .iEN(iEN), .iRD_DATA(data1), .iRD_VALID(iRD_VALID),
    .iUF_CLR(iUF_CLR), .oRD_REQ(req1), .oNew_Frame(nf1), .oEnd_Frame(ef1), .oRUN(run1),
    .oUNDERFLOW(uf1), .oHD(hd1), .oVD(vd1), .oDE(de1), .oLCD_R(r1), .oLCD_G(g1), .oLCD_B(b1));

  always #5 iCLK = ~iCLK;

  logic [31:0] obs0, obs1;
  assign obs0 = {req0, nf0, ef0, run0, uf0, hd0, vd0, de0, r0, g0, b0};
  assign obs1 = {req1, nf1, ef1, run1, uf1, hd1, vd1, de1, 6'b0, r1, g1, b1};

  int checks = 0, errors = 0, n = 0;

  // Reference model: frame time t, run mode, and a history of raster flags.
  int          lat [2] = '{LAT0, LAT1};
  bit          pol [2] = '{1'b1, 1'b0};
  int          mode [2], t [2], dc [2], pos [2];
  bit          stopP [2], uf [2], eHd [2], eVd [2], eDe [2];
  logic [23:0] eRgb [2];
  bit          hAct [2][16], hHs [2][16], hVs [2][16];

  int  dropRate = 0, clrRate = 0;
  bit  statsOn = 1'b0;
  int  reqCnt, deCnt0, hdLow0, hdHigh1, efCnt, runLow;
  int  firstReq, firstDe0, firstDe1, firstNf, nfPeriod;

  function automatic logic [23:0] ufc(int k);
    logic [23:0] m;
    m = (k == 1) ? 24'h03FFFF : 24'hFFFFFF;
    return 24'hFF00FF & m;
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mode[k] = 0; t[k] = 0; dc[k] = 0; pos[k] = 0;
      stopP[k] = 1'b0; uf[k] = 1'b0; eDe[k] = 1'b0; eRgb[k] = '0;
      eHd[k] = pol[k]; eVd[k] = pol[k];
      for (int i = 0; i < 16; i++) begin
        hAct[k][i] = 1'b0; hHs[k][i] = 1'b0; hVs[k][i] = 1'b0;
      end
    end
  endtask

  task automatic stepK(int k);
    bit running, act, hs, vs, dAct, dHs, dVs;
    int x, y, back;
    logic [31:0] e;
    logic [23:0] d;
    running = (mode[k] == 1);
    x = t[k] % HT;
    y = t[k] / HT;
    act = running && x >= HA0 && x < HA0 + HACT && y >= VA0 && y < VA0 + VACT;
    hs  = running && x < HS;
    vs  = running && y < VS;
    e = {act, running && t[k] == 0, act && x == HA0 + HACT - 1 && y == VA0 + VACT - 1,
         mode[k] != 0, uf[k], eHd[k], eVd[k], eDe[k], eRgb[k]};
    checks++;
    assert ((k == 0 ? obs0 : obs1) === e) else begin
      errors++;
      $error("FAIL pins%0d n=%0d obs=%h exp=%h", k, n, (k == 0 ? obs0 : obs1), e);
    end
    // Output registers next cycle reflect raster flags from lat cycles ago.
    back = (pos[k] - lat[k]) & 15;
    dAct = hAct[k][back]; dHs = hHs[k][back]; dVs = hVs[k][back];
    d = (k == 1) ? {6'b0, data1} : data0;
    eDe[k] = dAct;
    eHd[k] = dHs ^ pol[k];
    eVd[k] = dVs ^ pol[k];
    if (dAct && iRD_VALID)  eRgb[k] = d;
    else if (dAct)          eRgb[k] = ufc(k);
    else                    eRgb[k] = '0;
    if (dAct && !iRD_VALID) uf[k] = 1'b1;
    else if (iUF_CLR)       uf[k] = 1'b0;
    hAct[k][pos[k]] = act; hHs[k][pos[k]] = hs; hVs[k][pos[k]] = vs;
    pos[k] = (pos[k] + 1) & 15;
    if (mode[k] == 0) begin
      if (iEN) begin mode[k] = 1; t[k] = 0; stopP[k] = 1'b0; end
    end else if (mode[k] == 1) begin
      if (t[k] == FT - 1) begin
        t[k] = 0;
        if (stopP[k]) begin mode[k] = 2; dc[k] = 0; end
      end else begin
        t[k] = t[k] + 1;
      end
      stopP[k] = (mode[k] == 1) ? !iEN : 1'b0;
    end else begin
      if (dc[k] == lat[k]) mode[k] = 0;
      else dc[k] = dc[k] + 1;
    end
  endtask

  task automatic statsClear();
    reqCnt = 0; deCnt0 = 0; hdLow0 = 0; hdHigh1 = 0; efCnt = 0; runLow = 0;
    firstReq = -1; firstDe0 = -1; firstDe1 = -1; firstNf = -1; nfPeriod = -1;
  endtask

  // Called at a falling edge: drive this cycle's inputs, check, advance model.
  task automatic cycle();
    iRD_VALID = (dropRate == 0) ? 1'b1 : ($urandom_range(1, dropRate) != 1);
    iUF_CLR   = (clrRate == 0) ? 1'b0 : ($urandom_range(1, clrRate) == 1);
    data0     = 24'($urandom);
    data1     = 18'($urandom);
    #1;
    stepK(0);
    stepK(1);
    if (statsOn) begin
      if (req0) begin reqCnt++; if (firstReq < 0) firstReq = n; end
      if (de0) begin deCnt0++; if (firstDe0 < 0) firstDe0 = n; end
      if (de1 && firstDe1 < 0) firstDe1 = n;
      if (!hd0) hdLow0++;
      if (hd1) hdHigh1++;
      if (ef0) efCnt++;
      if (!run0) runLow++;
      if (nf0) begin
        if (firstNf < 0) firstNf = n;
        else if (nfPeriod < 0) nfPeriod = n - firstNf;
      end
    end
    n++;
    @(negedge iCLK);
  endtask

  initial begin
    int fall0, fall1, j;
    modelReset();
    statsClear();
    #2 iRST_n = 1'b0;
    #1;
    chk("reset0", obs0, 32'h0600_0000);
    chk("reset1", obs1, 32'h0000_0000);
    @(negedge iCLK);
    @(negedge iCLK);
    iRST_n = 1'b1;

    repeat (5) cycle();

    // Start with clean reads: raster position, latency and pulse counts.
    statsClear();
    statsOn = 1'b1;
    iEN = 1'b1;
    repeat (1 + 2 * FT) cycle();
    statsOn = 1'b0;
    chk("first_req_ofs", firstReq - firstNf, VA0 * HT + HA0);
    chk("de_lat0", firstDe0 - firstReq, LAT0 + 1);
    chk("de_lat1", firstDe1 - firstReq, LAT1 + 1);
    chk("req_count", reqCnt, 2 * HACT * VACT);
    chk("de_count", deCnt0, 2 * HACT * VACT);
    chk("hs_low0", hdLow0, 2 * VT * HS);
    chk("hs_high1", hdHigh1, 2 * VT * HS);
    chk("end_frames", efCnt, 2);
    chk("nf_period", nfPeriod, FT);

    // Random underflows with random clears.
    dropRate = 8; clrRate = 6;
    repeat (3 * FT) cycle();
    // Clear held high while underflows keep arriving.
    dropRate = 4; clrRate = 1;
    repeat (FT) cycle();

    // Brief iEN drop well before the wrap must not stop the raster.
    dropRate = 0;
    repeat (50) cycle();
    clrRate = 0;
    iEN = 1'b0;
    repeat (STOP_T - 50) cycle();
    iEN = 1'b1;
    statsClear();
    statsOn = 1'b1;
    repeat (2 * FT) cycle();
    statsOn = 1'b0;
    chk("no_stop", runLow, 0);

    // Stop mid-frame: frame completes, then RD_LAT+1 drain cycles.
    iEN = 1'b0;
    fall0 = -1; fall1 = -1; j = 0;
    while ((fall0 < 0 || fall1 < 0) && j < 3 * FT) begin
      if (!run0 && fall0 < 0) fall0 = j;
      if (!run1 && fall1 < 0) fall1 = j;
      cycle();
      j++;
    end
    chk("stop_done", 32'(fall0 >= 0 && fall1 >= 0), 1);
    chk("drain_fall0", fall0, FT - STOP_T + LAT0 + 1);
    chk("drain_diff", fall1 - fall0, LAT1 - LAT0);
    chk("idle0", obs0, 32'h0600_0000);
    chk("idle1", obs1, 32'h0000_0000);
    repeat (4) cycle();

    // Async reset in the middle of an active line, then restart from idle.
    dropRate = 6; clrRate = 5;
    iEN = 1'b1;
    repeat (FT / 2 + 7) cycle();
    #2 iRST_n = 1'b0;
    #1;
    chk("arst0", obs0, 32'h0600_0000);
    chk("arst1", obs1, 32'h0000_0000);
    modelReset();
    @(negedge iCLK);
    @(negedge iCLK);
    iRST_n = 1'b1;
    repeat (FT + 10) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
